// File: rtl/vend_coin_feeder.sv
`default_nettype none
// ============================================================================
// Module : vend_coin_feeder
// Brief  : Feeds wallet coins back-to-back into a vending FSM, then waits
//          for its dispense/change answer with a bounded timeout.
// Rev    : 1.0  initial release
// ============================================================================
module vend_coin_feeder #(
  parameter int PRICE   = 3,
  parameter int TIMEOUT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] n1_avail,
  input  logic [3:0] n2_avail,
  output logic       i,
  output logic       j,
  input  logic       x,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       vended,
  output logic       change,
  output logic       err,
  output logic [1:0] used1,
  output logic [1:0] used2
);

  // Credit may overshoot PRICE by one when the last coin is a 2-unit coin.
  localparam int CW = $clog2(PRICE + 3);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FEED = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [CW-1:0] c_price  = CW'(PRICE);
  localparam logic [5:0]    c_price6 = 6'(PRICE);
  localparam logic [TW-1:0] c_tmax   = TW'(TIMEOUT - 1);

  logic [1:0]    r_state, w_state_nxt;
  logic [3:0]    r_n1, r_n2, w_n1_nxt, w_n2_nxt;
  logic [CW-1:0] r_credit, w_credit_nxt;
  logic [TW-1:0] r_wcnt, w_wcnt_nxt;
  logic          r_i, r_j, r_busy, r_done, r_vended, r_change, r_err;
  logic          w_i_nxt, w_j_nxt, w_busy_nxt, w_done_nxt;
  logic          w_vended_nxt, w_change_nxt, w_err_nxt;
  logic [1:0]    r_used1, r_used2, w_used1_nxt, w_used2_nxt;

  logic          w_in_idle, w_funds_ok, w_load, w_take2;
  logic [5:0]    w_funds;
  logic [3:0]    w_src_n1, w_src_n2;
  logic [CW-1:0] w_src_credit, w_rem;
  logic [1:0]    w_base_used1, w_base_used2;

  // The first coin is chosen straight from the wallet inputs at the start edge.
  assign w_in_idle    = (r_state == S_IDLE);
  assign w_funds      = {2'b00, n1_avail} + {1'b0, n2_avail, 1'b0};
  assign w_funds_ok   = (w_funds >= c_price6);
  assign w_src_n1     = w_in_idle ? n1_avail : r_n1;
  assign w_src_n2     = w_in_idle ? n2_avail : r_n2;
  assign w_src_credit = w_in_idle ? '0 : r_credit;
  assign w_base_used1 = w_in_idle ? 2'd0 : r_used1;
  assign w_base_used2 = w_in_idle ? 2'd0 : r_used2;
  assign w_rem        = c_price - w_src_credit;
  assign w_take2      = ((w_rem >= CW'(2)) && (w_src_n2 != 4'd0)) || (w_src_n1 == 4'd0);
  assign w_load       = (w_in_idle && start && w_funds_ok) ||
                        ((r_state == S_FEED) && (r_credit < c_price));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = w_funds_ok ? S_FEED : S_FIN;
      S_FEED:  if (r_credit >= c_price) w_state_nxt = S_WAIT;
      S_WAIT:  if (x || (r_wcnt == c_tmax)) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_i_nxt      = 1'b0;
    w_j_nxt      = 1'b0;
    w_done_nxt   = 1'b0;
    w_busy_nxt   = r_busy;
    w_vended_nxt = r_vended;
    w_change_nxt = r_change;
    w_err_nxt    = r_err;
    w_used1_nxt  = r_used1;
    w_used2_nxt  = r_used2;
    w_n1_nxt     = r_n1;
    w_n2_nxt     = r_n2;
    w_credit_nxt = r_credit;
    w_wcnt_nxt   = r_wcnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_busy_nxt   = 1'b1;
          w_n1_nxt     = n1_avail;
          w_n2_nxt     = n2_avail;
          w_credit_nxt = '0;
          w_vended_nxt = 1'b0;
          w_change_nxt = 1'b0;
          w_used1_nxt  = 2'd0;
          w_used2_nxt  = 2'd0;
          w_err_nxt    = !w_funds_ok;
        end
      end
      S_FEED: begin
        if (r_credit >= c_price) w_wcnt_nxt = '0;
      end
      S_WAIT: begin
        if (x) begin
          w_vended_nxt = 1'b1;
          w_change_nxt = y;
        end else if (r_wcnt == c_tmax) begin
          w_err_nxt = 1'b1;
        end else begin
          w_wcnt_nxt = r_wcnt + TW'(1);
        end
      end
      S_FIN: begin
        w_done_nxt = 1'b1;
        w_busy_nxt = 1'b0;
      end
      default: ;
    endcase
    // Coins go out on consecutive cycles; a gap would lose the 2-unit credit.
    if (w_load) begin
      w_i_nxt = 1'b1;
      w_j_nxt = w_take2;
      if (w_take2) begin
        w_n2_nxt     = w_src_n2 - 4'd1;
        w_used2_nxt  = w_base_used2 + 2'd1;
        w_credit_nxt = w_src_credit + CW'(2);
      end else begin
        w_n1_nxt     = w_src_n1 - 4'd1;
        w_used1_nxt  = w_base_used1 + 2'd1;
        w_credit_nxt = w_src_credit + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_i      <= 1'b0;
      r_j      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_vended <= 1'b0;
      r_change <= 1'b0;
      r_err    <= 1'b0;
      r_used1  <= 2'd0;
      r_used2  <= 2'd0;
      r_n1     <= 4'd0;
      r_n2     <= 4'd0;
      r_credit <= '0;
      r_wcnt   <= '0;
    end else begin
      r_i      <= w_i_nxt;
      r_j      <= w_j_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_vended <= w_vended_nxt;
      r_change <= w_change_nxt;
      r_err    <= w_err_nxt;
      r_used1  <= w_used1_nxt;
      r_used2  <= w_used2_nxt;
      r_n1     <= w_n1_nxt;
      r_n2     <= w_n2_nxt;
      r_credit <= w_credit_nxt;
      r_wcnt   <= w_wcnt_nxt;
    end
  end

  assign i      = r_i;
  assign j      = r_j;
  assign busy   = r_busy;
  assign done   = r_done;
  assign vended = r_vended;
  assign change = r_change;
  assign err    = r_err;
  assign used1  = r_used1;
  assign used2  = r_used2;

endmodule
`default_nettype wire
